demux_rr_arbiter: RTL and testbench
===================================

DEMUX_RR_ARBITER -- requirements
Module: demux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive cycles one grant may be held; the legal range is 1..7.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk  input  1  system clock; all state SHALL change on the rising edge only.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port en  input  1  arbitration enable.
REQ-006 Port req  input  8  request per output line 0..7 of the downstream 1-to-8 demux.
REQ-007 Port gnt  output  8  registered one-hot grant, at most one bit high.
REQ-008 Port gnt_id  output  3  binary index of the granted line; it SHALL be the demux select value.
REQ-009 Port gnt_valid  output  1  high exactly when gnt is nonzero; it SHALL be the demux data/enable input.
REQ-010 Port busy  output  1  high in states GRANT and GAP.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-012 The block SHALL hold a 3-bit round-robin pointer ptr and a 3-bit hold counter hcnt.
REQ-013 IDLE, rising edge with en=1 and req!=0:
- the block SHALL select the first i with req[i]=1, scanning ptr, ptr+1, ... mod 8;
- it SHALL set gnt=1<<i, gnt_id=i, gnt_valid=1 and hcnt=1;
- it SHALL go to GRANT.
REQ-014 Grant latency SHALL be one edge: a request present at edge k SHALL be visible on gnt immediately after edge k.
REQ-015 IDLE with en=0 or req=0: the block SHALL stay in IDLE with gnt=0.
REQ-016 GRANT, at each edge:
- if req[gnt_id]=0, en=0 or hcnt=MAX_HOLD, the block SHALL clear gnt, set ptr=gnt_id+1 mod 8 and go to GAP;
- otherwise it SHALL keep gnt and increment hcnt.
REQ-017 A grant SHALL therefore last at most MAX_HOLD cycles.
REQ-018 GAP SHALL last exactly one cycle with gnt=0 and then go to IDLE; no grant SHALL be issued on the GAP-exit edge.
REQ-019 The minimum spacing between two grants SHALL be two gnt-low cycles: the GAP cycle and the IDLE arbitration cycle.
REQ-020 Changes on req bits other than gnt_id during GRANT SHALL NOT affect the current grant.
REQ-021 Pointer wrap: ptr=7 plus 1 SHALL give 0, and the scan SHALL wrap from 7 to 0.
REQ-022 A granted line that still requests after its grant SHALL have the lowest priority in the next arbitration, unless it is the only requester, in which case it SHALL be re-granted.
REQ-023 gnt_valid SHALL equal OR(gnt), and gnt_id SHALL be 0 whenever gnt=0.
REQ-024 The block SHALL contain no combinational path from req to gnt; all outputs SHALL be registered.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set state=IDLE, ptr=0, hcnt=0, gnt=8'h00, gnt_id=0, gnt_valid=0 and busy=0.
REQ-026 rst SHALL take priority over all other inputs.
REQ-027 rst asserted during GRANT SHALL drop gnt on that same edge, with no GAP cycle.
REQ-028 The first edge after rst deasserts SHALL arbitrate from ptr=0.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then req=8'h01 held, en=1, MAX_HOLD=4 -> gnt=8'h01 for 4 cycles, 0 for 2 cycles, then 8'h01 again.
- req=8'hFF held -> grant order 0,1,2,...,7,0, each grant 4 cycles long, each gnt_id matching its gnt bit.
- In IDLE with ptr=6 and req=8'h41 -> gnt=8'h40, then after the gap gnt=8'h01.
- Grant on line 3, req[3] dropped after 2 grant cycles -> gnt=0 on the next edge, busy high for the GAP cycle only, ptr=4.
- en dropped mid-grant -> gnt=0 on the next edge; with en=0, req=8'hFF produces no further grants.
- rst pulsed during GRANT -> all outputs 0 on that edge; the next grant goes to the lowest requesting index starting from 0.
REQ-030 A checker SHALL assert throughout every scenario that gnt is one-hot or zero, gnt_valid equals OR(gnt), and no grant exceeds MAX_HOLD cycles.

Source files
------------

// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter that drives the select and enable of a 1-to-8 demux.
// A grant is held for up to MAX_HOLD cycles and is followed by a one-cycle gap.
module demux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic [2:0] hcnt, hcnt_n;
    logic [7:0] gnt_n;
    logic [2:0] id_n;
    logic       found;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       release_now;

    // Scan the requests starting at ptr, wrapping 7 -> 0
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = '0;
        for (int j = 0; j < 8; j++) begin
            idx = ptr + 3'(j);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // A grant ends when its line stops requesting, en drops or the hold limit is hit
    always_comb begin
        release_now = !req[gnt_id] || !en || (hcnt == 3'(MAX_HOLD));
    end

    // Next-state and next-output logic; all outputs come from registers
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hcnt_n  = hcnt;
        gnt_n   = gnt;
        id_n    = gnt_id;
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                id_n  = '0;
                if (en && found) begin
                    gnt_n   = 8'b1 << pick;
                    id_n    = pick;
                    hcnt_n  = 3'd1;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_n   = '0;
                    id_n    = '0;
                    ptr_n   = gnt_id + 3'd1;
                    state_n = GAP;
                end else begin
                    hcnt_n = hcnt + 3'd1;
                end
            end
            GAP: begin
                gnt_n   = '0;
                id_n    = '0;
                state_n = IDLE;
            end
            default: begin
                gnt_n   = '0;
                id_n    = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides everything, including a live grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hcnt      <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hcnt      <= hcnt_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= |gnt_n;
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_demux_rr_arbiter.sv
// Directed bench for demux_rr_arbiter with MAX_HOLD=4.
// Each scenario task checks its own expected outputs after the clock edge.
module tb_demux_rr_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    int run = 0;
    logic [7:0] prev_gnt = '0;

    demux_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Invariant checker sampled on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            n_cmp++;
            if ((gnt & (gnt - 8'd1)) !== 8'd0) begin
                n_bad++;
                $display("FAIL onehot: gnt=%b required one-hot or zero", gnt);
            end
            n_cmp++;
            if (gnt_valid !== (|gnt)) begin
                n_bad++;
                $display("FAIL valid_or: gnt_valid=%b required %b", gnt_valid, |gnt);
            end
            n_cmp++;
            if (gnt == 8'd0 && gnt_id !== 3'd0) begin
                n_bad++;
                $display("FAIL id_zero: gnt_id=%0d required 0", gnt_id);
            end
            if (gnt != 8'd0 && gnt == prev_gnt) run++;
            else if (gnt != 8'd0) run = 1;
            else run = 0;
            prev_gnt = gnt;
            n_cmp++;
            if (run > MAXH) begin
                n_bad++;
                $display("FAIL max_hold: run=%0d required <= %0d", run, MAXH);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] eg,
                              input logic [2:0] eid, input logic eb);
        n_cmp++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== (|eg) || busy !== eb) begin
            n_bad++;
            $display("FAIL %s: gnt=%h id=%0d valid=%b busy=%b required gnt=%h id=%0d valid=%b busy=%b",
                     nm, gnt, gnt_id, gnt_valid, busy, eg, eid, |eg, eb);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        tick;
        tick;
        rst = 1'b0;
        en  = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_reset;
        do_reset;
        chk_on = 1'b1;
        rst = 1'b1;
        en  = 1'b1;
        req = 8'hFF;
        tick;
        expect_out("reset_prio", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        en  = 1'b0;
        req = 8'h00;
        tick;
        expect_out("reset_idle", 8'h00, 3'd0, 1'b0);
    endtask

    task automatic test_single;
        do_reset;
        en  = 1'b1;
        req = 8'h01;
        for (int i = 0; i < 4; i++) begin
            tick;
            expect_out($sformatf("single_hold%0d", i), 8'h01, 3'd0, 1'b1);
        end
        tick;
        expect_out("single_gap", 8'h00, 3'd0, 1'b1);
        tick;
        expect_out("single_idle", 8'h00, 3'd0, 1'b0);
        tick;
        expect_out("single_regrant", 8'h01, 3'd0, 1'b1);
    endtask

    task automatic test_all_req;
        logic [2:0] ln;
        do_reset;
        en  = 1'b1;
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            ln = 3'(g % 8);
            for (int i = 0; i < 4; i++) begin
                tick;
                expect_out($sformatf("rr_g%0d_c%0d", g, i), 8'h01 << ln, ln, 1'b1);
            end
            tick;
            expect_out($sformatf("rr_gap%0d", g), 8'h00, 3'd0, 1'b1);
            tick;
            expect_out($sformatf("rr_idle%0d", g), 8'h00, 3'd0, 1'b0);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        en  = 1'b1;
        req = 8'h20;
        tick;
        expect_out("wrap_g5", 8'h20, 3'd5, 1'b1);
        req = 8'h00;
        tick;
        tick;
        req = 8'h41;
        tick;
        expect_out("wrap_g6", 8'h40, 3'd6, 1'b1);
        tick;
        tick;
        tick;
        tick;
        expect_out("wrap_gap", 8'h00, 3'd0, 1'b1);
        tick;
        tick;
        expect_out("wrap_g0", 8'h01, 3'd0, 1'b1);
    endtask

    task automatic test_drop;
        do_reset;
        en  = 1'b1;
        req = 8'h08;
        tick;
        expect_out("drop_c1", 8'h08, 3'd3, 1'b1);
        tick;
        expect_out("drop_c2", 8'h08, 3'd3, 1'b1);
        req = 8'h00;
        tick;
        expect_out("drop_gap", 8'h00, 3'd0, 1'b1);
        tick;
        expect_out("drop_idle", 8'h00, 3'd0, 1'b0);
        req = 8'hFF;
        tick;
        expect_out("drop_ptr4", 8'h10, 3'd4, 1'b1);
    endtask

    task automatic test_en_drop;
        do_reset;
        en  = 1'b1;
        req = 8'hFF;
        tick;
        tick;
        expect_out("en_grant", 8'h01, 3'd0, 1'b1);
        en = 1'b0;
        tick;
        expect_out("en_cut", 8'h00, 3'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick;
            expect_out($sformatf("en_off%0d", i), 8'h00, 3'd0, 1'b0);
        end
    endtask

    task automatic test_rst_grant;
        do_reset;
        en  = 1'b1;
        req = 8'hFF;
        repeat (7) tick;
        expect_out("rg_line1", 8'h02, 3'd1, 1'b1);
        rst = 1'b1;
        tick;
        expect_out("rg_rst", 8'h00, 3'd0, 1'b0);
        rst = 1'b0;
        req = 8'h03;
        tick;
        expect_out("rg_from0", 8'h01, 3'd0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        test_reset;
        test_single;
        test_all_req;
        test_wrap;
        test_drop;
        test_en_drop;
        test_rst_grant;
        tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
